// File: rtl/metaball_field.sv
// metaball_field: field contribution RAD^2 / ((p_x-x)^2 + (p_y-y)^2) of one bouncing ball.
// Ports: clk, rst (async, active-high); mov_en steps the ball; px_stb starts a computation
//        on (p_x, p_y); vld=1 when idle with out valid. Fixed latency 51 cycles, px_stb ignored while busy.
module metaball_field #(
  parameter logic signed [31:0] RAD   = 32'sh0001_4000,
  parameter logic signed [31:0] I_X   = 32'sh0007_C000,
  parameter logic signed [31:0] I_Y   = 32'sh0000_0000,
  parameter logic signed [31:0] IV_Y  = 32'sh0004_0CCC,
  parameter logic signed [31:0] Y_MAX = 32'sh0020_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mov_en,
  input  logic               px_stb,
  input  logic signed [31:0] p_x,
  input  logic signed [31:0] p_y,
  output logic               vld,
  output logic        [31:0] out
);

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;

  // Q15 multiply: full signed product shifted down 15 (floor), positive overflow saturates.
  function automatic logic [31:0] fx_mul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] prod;
    logic signed [63:0] shr;
    prod = a * b;
    shr  = prod >>> 15;
    if (!shr[63] && (|shr[62:31])) return SAT_MAX;
    return shr[31:0];
  endfunction

  localparam logic [31:0] RR_C = fx_mul(RAD, RAD);

  typedef enum logic [2:0] {IDLE, DELTA, SQUARE, SUM, DIV} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] y_q, y_d, vy_q, vy_d;
  logic signed [31:0] px_cap_q, py_cap_q, y_cap_q;
  logic signed [31:0] dx_q, dy_q;
  logic        [31:0] dx_sq_q, dy_sq_q, divisor_q, dividend_q;
  logic        [31:0] rem_q, rem_d;
  logic        [46:0] quo_q, quo_d;
  logic        [5:0]  cnt_q;
  logic        [31:0] out_q;
  logic        [31:0] sum_w;
  logic        [46:0] num_w;
  logic signed [32:0] y_nxt_w;

  assign vld = (state_q == IDLE);
  assign out = out_q;

  // Both squares are non-negative, so a set bit 31 is the only overflow indication.
  assign sum_w   = dx_sq_q + dy_sq_q;
  assign num_w   = {dividend_q, 15'd0};
  assign y_nxt_w = {y_q[31], y_q} + {vy_q[31], vy_q};

  // Bounce: clamp to the wall and reflect the velocity.
  always_comb begin
    y_d  = y_q;
    vy_d = vy_q;
    if (mov_en) begin
      if (y_nxt_w[32]) begin
        y_d  = '0;
        vy_d = -vy_q;
      end else if (y_nxt_w > $signed({Y_MAX[31], Y_MAX})) begin
        y_d  = Y_MAX;
        vy_d = -vy_q;
      end else begin
        y_d  = y_nxt_w[31:0];
      end
    end
  end

  // One restoring step: numerator bits are fed MSB first, quotient bits shift in at the bottom.
  always_comb begin
    logic [32:0] shifted;
    shifted = {rem_q, num_w[6'd46 - cnt_q]};
    rem_d   = shifted[31:0];
    quo_d   = {quo_q[45:0], 1'b0};
    if (shifted >= {1'b0, divisor_q}) begin
      rem_d = 32'(shifted - {1'b0, divisor_q});
      quo_d = {quo_q[45:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (px_stb) state_d = DELTA;
      DELTA:   state_d = SQUARE;
      SQUARE:  state_d = SUM;
      SUM:     state_d = DIV;
      DIV:     if (cnt_q == 6'd47) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      y_q        <= I_Y;
      vy_q       <= IV_Y;
      px_cap_q   <= '0;
      py_cap_q   <= '0;
      y_cap_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      dx_sq_q    <= '0;
      dy_sq_q    <= '0;
      divisor_q  <= '0;
      dividend_q <= RR_C;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      case (state_q)
        IDLE: begin
          // y_q here is the pre-motion value even if mov_en fires on the same edge.
          if (px_stb) begin
            px_cap_q <= p_x;
            py_cap_q <= p_y;
            y_cap_q  <= y_q;
          end
        end
        DELTA: begin
          // x never moves, so its captured value is always I_X.
          dx_q <= px_cap_q - I_X;
          dy_q <= py_cap_q - y_cap_q;
        end
        SQUARE: begin
          dx_sq_q <= fx_mul(dx_q, dx_q);
          dy_sq_q <= fx_mul(dy_q, dy_q);
        end
        SUM: begin
          divisor_q  <= sum_w[31] ? SAT_MAX : sum_w;
          dividend_q <= RR_C;
          rem_q      <= '0;
          quo_q      <= '0;
          cnt_q      <= '0;
        end
        DIV: begin
          if (cnt_q != 6'd47) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
          end else if ((divisor_q == '0) || (|quo_q[46:31])) begin
            out_q <= SAT_MAX;
          end else begin
            out_q <= {1'b0, quo_q[30:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_metaball_field.sv
module tb_metaball_field;

  localparam int RAD   = 32'h0001_4000;
  localparam int I_X   = 32'h0007_C000;
  localparam int I_Y   = 32'h0000_0000;
  localparam int IV_Y  = 32'h0004_0CCC;
  localparam int Y_MAX = 32'h0020_0000;
  localparam longint SAT = 64'h7FFF_FFFF;

  logic               clk = 1'b0;
  logic               rst;
  logic               mov_en;
  logic               px_stb;
  logic signed [31:0] p_x;
  logic signed [31:0] p_y;
  logic               vld;
  logic        [31:0] out_w;

  metaball_field dut (
    .clk    (clk),
    .rst    (rst),
    .mov_en (mov_en),
    .px_stb (px_stb),
    .p_x    (p_x),
    .p_y    (p_y),
    .vld    (vld),
    .out    (out_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    int          acc;
  } exp_t;

  exp_t   sb[$];
  int     compared   = 0;
  int     mismatched = 0;
  int     cyc        = 0;
  int     y_m, vy_m;
  longint yn;
  logic   prev_vld   = 1'b1;
  logic [31:0] last_out = '0;

  always @(posedge clk) cyc++;

  // Ball motion model: plain bounce arithmetic on integers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      y_m  = I_Y;
      vy_m = IV_Y;
    end else if (mov_en) begin
      yn = longint'(y_m) + longint'(vy_m);
      if (yn < 0) begin
        y_m = 0; vy_m = -vy_m;
      end else if (yn > longint'(Y_MAX)) begin
        y_m = Y_MAX; vy_m = -vy_m;
      end else begin
        y_m = int'(yn);
      end
    end
  end

  function automatic longint sq_q15(input int d);
    longint p;
    p = (longint'(d) * longint'(d)) >>> 15;
    if (p > SAT) p = SAT;
    return p;
  endfunction

  function automatic logic [31:0] ref_field(input int px, input int py, input int y);
    longint den, num, quo;
    int dx, dy;
    dx  = px - I_X;
    dy  = py - y;
    den = sq_q15(dx) + sq_q15(dy);
    if (den > SAT) den = SAT;
    if (den == 0) return 32'h7FFF_FFFF;
    num = ((longint'(RAD) * longint'(RAD)) >>> 15) << 15;
    quo = num / den;
    if (quo > SAT) quo = SAT;
    return quo[31:0];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: a rising vld is a completion; otherwise out must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_vld = 1'b1;
      last_out = '0;
    end else begin
      if (vld && !prev_vld) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got out=%0h with no pending request", out_w);
        end else begin
          e = sb.pop_front();
          chk("result", out_w, e.v);
          chk("latency", cyc - e.acc, 51);
        end
        last_out = out_w;
      end else begin
        chk("out_hold", out_w, last_out);
      end
      prev_vld = vld;
    end
  end

  // Drive one cycle of inputs at a negedge; an accepted strobe queues its expectation.
  task automatic step(input logic mv, input logic stb, input int px, input int py);
    mov_en = mv;
    px_stb = stb;
    p_x    = px;
    p_y    = py;
    if (stb && vld && !rst) sb.push_back('{ref_field(px, py, y_m), cyc + 1});
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !vld) && n < 200) begin
      step(1'b0, 1'b0, 0, 0);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), n);
    end
    step(1'b0, 1'b0, 0, 0);
  endtask

  function automatic int rnd_coord();
    if ($urandom_range(0, 15) == 0) return int'($urandom());
    return int'($urandom_range(0, 5242880)) - 2621440;
  endfunction

  initial begin
    rst = 1'b1; mov_en = 1'b0; px_stb = 1'b0; p_x = '0; p_y = '0;
    repeat (2) @(negedge clk);
    chk("reset_vld", vld, 1);
    chk("reset_out", out_w, 0);
    #3 rst = 1'b0;
    @(negedge clk);

    // Strobe held high at the origin: back-to-back results, one-cycle vld pulse between them.
    repeat (110) step(1'b0, 1'b1, 0, 0);
    wait_done();

    step(1'b0, 1'b1, 32'h0007_C000, 0);          // exactly at ball centre
    wait_done();
    step(1'b0, 1'b1, 32'h0009_0000, 32'h0002_0000); // (18.0, 4.0)
    wait_done();

    repeat (3) step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 32'h0007_C000, 0);
    wait_done();
    repeat (5) step(1'b1, 1'b0, 0, 0);             // reaches the Y_MAX clamp
    step(1'b0, 1'b1, 32'h0007_C000, 0);
    wait_done();
    step(1'b1, 1'b0, 0, 0);                         // now moving downward
    step(1'b0, 1'b1, 32'h0007_C000, 0);
    wait_done();

    // Strobes and motion while busy must not disturb the in-flight result.
    step(1'b0, 1'b1, 32'h0004_0000, 32'h0003_0000);
    repeat (5) step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 32'h0007_C000, 32'h0000_1000);
    repeat (3) step(1'b1, 1'b0, 0, 0);
    wait_done();

    // Reset in the middle of the division.
    step(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000);
    repeat (20) step(1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    #1;
    chk("abort_vld", vld, 1);
    chk("abort_out", out_w, 0);
    sb.delete();
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 32'h0007_C000, 0);            // motion on the capture edge
    wait_done();

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), rnd_coord(), rnd_coord());
    end
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
